// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: Gray conversions and the full-compare helper.
// Functions work on zero-extended 32-bit words so they serve any pointer width.
package fifo_pkg;

   localparam int unsigned ADDR_W_DEFAULT = 8;
   localparam int unsigned PTR_MAX_W      = 32;

   typedef logic [PTR_MAX_W-1:0] ptr_word_t;

   function automatic ptr_word_t bin2gray(input ptr_word_t b);
      return b ^ (b >> 1);
   endfunction

   // Prefix XOR from the MSB down; leading zeros of a narrow pointer pass through.
   function automatic ptr_word_t gray2bin(input ptr_word_t g);
      ptr_word_t b;
      b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
      for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Gray image of (ptr + depth): top two bits of a width-w Gray pointer inverted.
   function automatic ptr_word_t full_cmp(input ptr_word_t g, input int unsigned w);
      return g ^ (ptr_word_t'(3) << (w - 2));
   endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing clock domains.
module gray_ptr_sync #(
   parameter int unsigned WIDTH  = 9,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] sync_q [STAGES];
   logic [WIDTH-1:0] sync_d [STAGES];

   always_comb begin
      sync_d[0] = d_i;
      for (int i = 1; i < STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and full/level/overflow controller of the async FIFO.
module wptr_full_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned ADDR_W       = ADDR_W_DEFAULT,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned AFULL_THRESH = 240
) (
   input  logic              wclk,
   input  logic              wrst,
   input  logic              wen,
   input  logic              ovf_clr,
   input  logic [ADDR_W:0]   rptr_gray,
   output logic              wr_accept,
   output logic [ADDR_W-1:0] waddr,
   output logic [ADDR_W:0]   wptr_bin,
   output logic [ADDR_W:0]   wptr_gray,
   output logic              full,
   output logic              almost_full,
   output logic [ADDR_W:0]   wlevel,
   output logic              overflow
);

   localparam int unsigned         PTR_W     = ADDR_W + 1;
   localparam logic [PTR_W-1:0]    AFULL_LVL = PTR_W'(AFULL_THRESH);

   logic [PTR_W-1:0] wptr_bin_q, wptr_bin_d;
   logic [PTR_W-1:0] wptr_gray_q, wptr_gray_d;
   logic [PTR_W-1:0] wlevel_q, wlevel_d;
   logic [PTR_W-1:0] rq_sync, rbin_sync;
   logic             full_q, full_d;
   logic             afull_q, afull_d;
   logic             ovf_q, ovf_d;

   gray_ptr_sync #(
      .WIDTH  (PTR_W),
      .STAGES (SYNC_STAGES)
   ) u_rptr_sync (
      .clk_i (wclk),
      .rst_i (wrst),
      .d_i   (rptr_gray),
      .q_o   (rq_sync)
   );

   assign wr_accept = wen & ~full_q;

   // Flags are computed from the next pointer so they track the write at the same edge.
   always_comb begin
      wptr_bin_d  = wptr_bin_q + {{ADDR_W{1'b0}}, wr_accept};
      wptr_gray_d = PTR_W'(bin2gray(ptr_word_t'(wptr_bin_d)));
      rbin_sync   = PTR_W'(gray2bin(ptr_word_t'(rq_sync)));
      wlevel_d    = wptr_bin_d - rbin_sync;
      full_d      = (wptr_gray_d == PTR_W'(full_cmp(ptr_word_t'(rq_sync), PTR_W)));
      afull_d     = (wlevel_d >= AFULL_LVL);
      ovf_d       = (wen & full_q) | (ovf_q & ~ovf_clr);
   end

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         wptr_bin_q  <= '0;
         wptr_gray_q <= '0;
         wlevel_q    <= '0;
         full_q      <= 1'b0;
         afull_q     <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         wptr_bin_q  <= wptr_bin_d;
         wptr_gray_q <= wptr_gray_d;
         wlevel_q    <= wlevel_d;
         full_q      <= full_d;
         afull_q     <= afull_d;
         ovf_q       <= ovf_d;
      end
   end

   assign waddr       = wptr_bin_q[ADDR_W-1:0];
   assign wptr_bin    = wptr_bin_q;
   assign wptr_gray   = wptr_gray_q;
   assign full        = full_q;
   assign almost_full = afull_q;
   assign wlevel      = wlevel_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Self-checking bench: directed scenarios plus random soak against an occupancy model.
module tb_wptr_full_ctrl;

   localparam int SYNC  = 2;
   localparam int DEPTH = 256;
   localparam int PMOD  = 512;

   logic       wclk, wrst, wen, ovf_clr, wr_accept, full, almost_full, overflow;
   logic [8:0] rptr_gray, wptr_bin, wptr_gray, wlevel;
   logic [7:0] waddr;

   wptr_full_ctrl #(
      .ADDR_W       (8),
      .SYNC_STAGES  (SYNC),
      .AFULL_THRESH (240)
   ) dut (
      .wclk        (wclk),
      .wrst        (wrst),
      .wen         (wen),
      .ovf_clr     (ovf_clr),
      .rptr_gray   (rptr_gray),
      .wr_accept   (wr_accept),
      .waddr       (waddr),
      .wptr_bin    (wptr_bin),
      .wptr_gray   (wptr_gray),
      .full        (full),
      .almost_full (almost_full),
      .wlevel      (wlevel),
      .overflow    (overflow)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   // Model: total writes/reads as plain counters; read pointer seen SYNC edges late.
   int         wr_cnt, rd_cnt, lvl_e;
   logic       full_e, af_e, ov_e;
   logic [8:0] hist[$];

   function automatic logic [8:0] g9(input int b);
      logic [8:0] v;
      v = 9'(b);
      return v ^ (v >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      wr_cnt = 0; rd_cnt = 0; lvl_e = 0;
      full_e = 1'b0; af_e = 1'b0; ov_e = 1'b0;
      hist.delete();
      repeat (SYNC) hist.push_back(9'd0);
   endtask

   task automatic check_outputs();
      chk("wptr_bin", wptr_bin, wr_cnt % PMOD);
      chk("wptr_gray", wptr_gray, g9(wr_cnt % PMOD));
      chk("waddr", waddr, wr_cnt % DEPTH);
      chk("full", full, full_e);
      chk("almost_full", almost_full, af_e);
      chk("wlevel", wlevel, lvl_e);
      chk("overflow", overflow, ov_e);
      chk("no_overrun", (wr_cnt - rd_cnt) <= DEPTH, 1);
      chk("level_pessimistic", int'(wlevel) >= (wr_cnt - rd_cnt), 1);
   endtask

   // Called just after a rising edge; drives one cycle and checks the result.
   task automatic step(input logic w, input logic c, input logic r);
      logic [8:0] rq;
      logic       acc;
      wen = w;
      ovf_clr = c;
      if (r && rd_cnt < wr_cnt) rd_cnt++;
      rptr_gray = g9(rd_cnt % PMOD);
      #1;
      chk("wr_accept", wr_accept, w && !full_e);
      @(posedge wclk);
      rq  = hist.pop_front();
      acc = w && !full_e;
      ov_e = (w && full_e) ? 1'b1 : (c ? 1'b0 : ov_e);
      if (acc) wr_cnt++;
      lvl_e  = ((wr_cnt % PMOD) - int'(rq) + PMOD) % PMOD;
      full_e = (lvl_e == DEPTH);
      af_e   = (lvl_e >= 240);
      hist.push_back(9'(rd_cnt % PMOD));
      #1;
      check_outputs();
   endtask

   logic [8:0] prev_gray, prev_bin;
   logic       wrapped;
   int         wp, rp;

   initial begin
      wrst = 1'b1; wen = 1'b0; ovf_clr = 1'b0; rptr_gray = '0;
      model_reset();
      #1;
      check_outputs();
      chk("reset_accept", wr_accept, 0);
      @(posedge wclk); #1;
      wrst = 1'b0;

      // Fill from empty with the reader stalled.
      for (int i = 1; i <= DEPTH; i++) begin
         step(1'b1, 1'b0, 1'b0);
         if (i == 239) chk("afull_before_240", almost_full, 0);
         if (i == 240) chk("afull_at_240", almost_full, 1);
         if (i == 255) chk("not_full_255", full, 0);
      end
      chk("fill_full", full, 1);
      chk("fill_level", wlevel, 256);
      chk("fill_bin", wptr_bin, 9'h100);
      chk("fill_gray", wptr_gray, 9'h180);

      // Overflow set, clear, and set-wins.
      step(1'b1, 1'b0, 1'b0);
      chk("ovf_set", overflow, 1);
      chk("ovf_ptr_hold", wptr_bin, 9'h100);
      step(1'b0, 1'b1, 1'b0);
      chk("ovf_clr", overflow, 0);
      step(1'b1, 1'b1, 1'b0);
      chk("ovf_set_wins", overflow, 1);
      step(1'b0, 1'b1, 1'b0);

      // Release one slot from the read side.
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("release_full", full, 0);
      chk("release_level", wlevel, 255);
      chk("release_waddr", waddr, 0);
      step(1'b1, 1'b0, 1'b0);
      chk("release_ptr", wptr_bin, 9'h101);

      // Asynchronous reset in the middle of a fill.
      wrst = 1'b1; #1; wrst = 1'b0;
      model_reset();
      step(1'b0, 1'b0, 1'b0);
      repeat (100) step(1'b1, 1'b0, 1'b0);
      chk("midfill_level", wlevel, 100);
      wen = 1'b0;
      #2;
      wrst = 1'b1;
      #1;
      model_reset();
      rptr_gray = '0;
      check_outputs();
      chk("midfill_accept", wr_accept, 0);
      @(posedge wclk); #1;
      wrst = 1'b0;
      chk("post_reset_waddr", waddr, 0);
      step(1'b1, 1'b0, 1'b0);
      chk("post_reset_ptr", wptr_bin, 1);

      // Wrap with the reader tracking the writer.
      wrapped = 1'b0;
      for (int i = 0; i < 600; i++) begin
         prev_gray = wptr_gray;
         prev_bin  = wptr_bin;
         step(1'b1, 1'b0, 1'b1);
         chk("no_spurious_full", full, 0);
         chk("gray_one_bit", $countones(prev_gray ^ wptr_gray) <= 1, 1);
         if (prev_bin == 9'h1FF && wptr_bin == 9'h000) wrapped = 1'b1;
      end
      chk("wrapped", wrapped, 1);

      // Random soak with alternating fill/drain bias.
      for (int blk = 0; blk < 6; blk++) begin
         wp = (blk % 2 == 0) ? 85 : 35;
         rp = (blk % 2 == 0) ? 30 : 90;
         for (int i = 0; i < 500; i++) begin
            prev_gray = wptr_gray;
            step(($urandom % 100) < wp, ($urandom % 20) == 0, ($urandom % 100) < rp);
            chk("soak_gray_one_bit", $countones(prev_gray ^ wptr_gray) <= 1, 1);
         end
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
